reg_capture_bank: RTL and testbench

Parametrised, multi-channel register block for the capture path: it serves the standard `reg_address`/`reg_bytecnt`/`reg_datai`/`reg_datao` bus on `clk_usb` for `pNUM_CH` identical capture channels. Each channel has the following:
- a multi-byte configuration register that updates atomically through a shared shadow;
- sticky write-1-to-clear event status;
- a coherent counter snapshot.

A command register issues self-clearing per-channel pulses and a stretched soft reset. The block sits beside the existing register block in the top-level register decode and drives per-channel capture logic.

---
 rtl/reg_capture_bank_pkg.sv | 35 +++
 rtl/reg_capture_chan.sv | 50 +++++
 rtl/reg_capture_bank.sv | 139 +++++++++++++
 tb/tb_reg_capture_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_capture_bank_pkg.sv
// rtl/reg_capture_bank_pkg.sv - register addresses, command bits and address decode for reg_capture_bank
package reg_capture_bank_pkg;

    localparam logic [7:0] ADDR_CHSEL = 8'h40;
    localparam logic [7:0] ADDR_CFG   = 8'h41;
    localparam logic [7:0] ADDR_STAT  = 8'h42;
    localparam logic [7:0] ADDR_SNAP  = 8'h43;
    localparam logic [7:0] ADDR_CMD   = 8'h44;

    localparam int CMD_SNAP_BIT    = 0;
    localparam int CMD_STATCLR_BIT = 1;
    localparam int CMD_PULSE_BIT   = 2;
    localparam int CMD_SRST_BIT    = 3;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CHSEL,
        REG_CFG,
        REG_STAT,
        REG_SNAP,
        REG_CMD
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [7:0] addr);
        case (addr)
            ADDR_CHSEL: return REG_CHSEL;
            ADDR_CFG:   return REG_CFG;
            ADDR_STAT:  return REG_STAT;
            ADDR_SNAP:  return REG_SNAP;
            ADDR_CMD:   return REG_CMD;
            default:    return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reg_capture_chan.sv
// rtl/reg_capture_chan.sv - per-channel live config, sticky event status and counter snapshot
module reg_capture_chan
    import reg_capture_bank_pkg::*;
#(
    parameter int               CFG_W     = 32,
    parameter logic [CFG_W-1:0] CFG_RESET = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [CFG_W-1:0] i_cfg_d,
    input  logic [7:0]       i_stat_set,
    input  logic [7:0]       i_stat_clr,
    input  logic             i_hold_clr,
    input  logic             i_snap_cap,
    input  logic [31:0]      i_snap_d,
    output logic [CFG_W-1:0] o_cfg,
    output logic [7:0]       o_stat,
    output logic [31:0]      o_snap
);

    logic [CFG_W-1:0] r_cfg;
    logic [7:0]       r_stat;
    logic [31:0]      r_snap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg  <= CFG_RESET;
            r_stat <= '0;
            r_snap <= '0;
        end else begin
            if (i_cfg_we)
                r_cfg <= i_cfg_d;
            // Set beats clear so an event racing a W1C is never lost.
            if (i_hold_clr)
                r_stat <= '0;
            else
                r_stat <= (r_stat & ~i_stat_clr) | i_stat_set;
            if (i_hold_clr)
                r_snap <= '0;
            else if (i_snap_cap)
                r_snap <= i_snap_d;
        end
    end

    assign o_cfg  = r_cfg;
    assign o_stat = r_stat;
    assign o_snap = r_snap;

endmodule

// File: rtl/reg_capture_bank.sv
// rtl/reg_capture_bank.sv - multi-channel capture register bank: channel select, shadowed config, commands, soft reset
module reg_capture_bank
    import reg_capture_bank_pkg::*;
#(
    parameter int                        pBYTECNT_SIZE = 7,
    parameter int                        pNUM_CH       = 4,
    parameter int                        pCFG_BYTES    = 4,
    parameter logic [pCFG_BYTES*8-1:0]   pCFG_RESET    = '0,
    parameter int                        pRST_CYCLES   = 16
) (
    input  logic                              clk_usb,
    input  logic                              reset_n,
    input  logic [7:0]                        reg_address,
    input  logic [pBYTECNT_SIZE-1:0]          reg_bytecnt,
    input  logic [7:0]                        reg_datai,
    output logic [7:0]                        reg_datao,
    input  logic                              reg_read,
    input  logic                              reg_write,
    input  logic [pNUM_CH*8-1:0]              event_i,
    input  logic [pNUM_CH*32-1:0]             counter_i,
    output logic [pNUM_CH*pCFG_BYTES*8-1:0]   cfg_o,
    output logic [pNUM_CH-1:0]                pulse_o,
    output logic                              soft_reset_o
);

    localparam int CFG_W = pCFG_BYTES * 8;
    localparam int CH_W  = (pNUM_CH > 1) ? $clog2(pNUM_CH) : 1;
    localparam int RST_W = $clog2(pRST_CYCLES + 1);
    localparam int BC_W  = pBYTECNT_SIZE;
    localparam logic [BC_W-1:0] LAST_BC = BC_W'(pCFG_BYTES - 1);

    reg_sel_e         w_sel;
    logic             w_wr_chsel, w_wr_cfg, w_wr_stat, w_wr_cmd, w_commit;
    logic [7:0]       w_cmd;
    logic             w_srst_start, w_srst_active, w_hold_clr;
    logic [CFG_W-1:0] w_shadow_nxt;

    logic [CH_W-1:0]    r_chsel;
    logic [CFG_W-1:0]   r_shadow;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [pNUM_CH-1:0] r_pulse;

    logic [CFG_W-1:0] w_cfg  [pNUM_CH];
    logic [7:0]       w_stat [pNUM_CH];
    logic [31:0]      w_snap [pNUM_CH];

    assign w_sel      = decode_addr(reg_address);
    assign w_wr_chsel = reg_write && (w_sel == REG_CHSEL);
    assign w_wr_cfg   = reg_write && (w_sel == REG_CFG) && (reg_bytecnt <= LAST_BC);
    assign w_wr_stat  = reg_write && (w_sel == REG_STAT);
    assign w_wr_cmd   = reg_write && (w_sel == REG_CMD);
    assign w_commit   = w_wr_cfg && (reg_bytecnt == LAST_BC);
    assign w_cmd      = w_wr_cmd ? reg_datai : 8'h00;

    // The committed value includes the byte being written on the committing cycle.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int k = 0; k < pCFG_BYTES; k++)
            if (w_wr_cfg && (reg_bytecnt == BC_W'(k)))
                w_shadow_nxt[k*8 +: 8] = reg_datai;
    end

    assign w_srst_start  = w_cmd[CMD_SRST_BIT];
    assign w_srst_active = (r_rst_cnt != '0);
    assign w_hold_clr    = w_srst_active || w_srst_start;
    assign soft_reset_o  = w_srst_active;
    assign pulse_o       = r_pulse;

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_chsel   <= '0;
            r_shadow  <= pCFG_RESET;
            r_rst_cnt <= '0;
            r_pulse   <= '0;
        end else begin
            if (w_wr_chsel && (reg_datai < 8'(pNUM_CH)))
                r_chsel <= reg_datai[CH_W-1:0];
            r_shadow <= w_shadow_nxt;
            if (w_srst_start)
                r_rst_cnt <= RST_W'(pRST_CYCLES);
            else if (w_srst_active)
                r_rst_cnt <= r_rst_cnt - 1'b1;
            r_pulse <= '0;
            if (w_cmd[CMD_PULSE_BIT])
                r_pulse[r_chsel] <= 1'b1;
        end
    end

    for (genvar c = 0; c < pNUM_CH; c++) begin : g_ch
        logic       w_hit;
        logic [7:0] w_clr;

        assign w_hit = (r_chsel == CH_W'(c));
        assign w_clr = w_hit ? ((w_wr_stat ? reg_datai : 8'h00) |
                                (w_cmd[CMD_STATCLR_BIT] ? 8'hFF : 8'h00)) : 8'h00;

        reg_capture_chan #(
            .CFG_W     (CFG_W),
            .CFG_RESET (pCFG_RESET)
        ) u_chan (
            .i_clk      (clk_usb),
            .i_rst_n    (reset_n),
            .i_cfg_we   (w_commit && w_hit),
            .i_cfg_d    (w_shadow_nxt),
            .i_stat_set (event_i[c*8 +: 8]),
            .i_stat_clr (w_clr),
            .i_hold_clr (w_hold_clr),
            .i_snap_cap (w_cmd[CMD_SNAP_BIT]),
            .i_snap_d   (counter_i[c*32 +: 32]),
            .o_cfg      (w_cfg[c]),
            .o_stat     (w_stat[c]),
            .o_snap     (w_snap[c])
        );

        assign cfg_o[c*CFG_W +: CFG_W] = w_cfg[c];
    end

    always_comb begin
        reg_datao = 8'h00;
        if (reg_read) begin
            case (w_sel)
                REG_CHSEL: reg_datao = 8'(r_chsel);
                REG_CFG: begin
                    for (int k = 0; k < pCFG_BYTES; k++)
                        if (reg_bytecnt == BC_W'(k))
                            reg_datao = w_cfg[r_chsel][k*8 +: 8];
                end
                REG_STAT: reg_datao = w_stat[r_chsel];
                REG_SNAP: begin
                    for (int k = 0; k < 4; k++)
                        if (reg_bytecnt == BC_W'(k))
                            reg_datao = w_snap[r_chsel][k*8 +: 8];
                end
                default: reg_datao = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_capture_bank.sv
// tb/tb_reg_capture_bank.sv - scoreboard bench for reg_capture_bank with directed vectors
module tb_reg_capture_bank;
    import reg_capture_bank_pkg::*;

    localparam logic [31:0] CRST = 32'h0000_0102;

    logic         clk_usb = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   reg_address = '0;
    logic [6:0]   reg_bytecnt = '0;
    logic [7:0]   reg_datai = '0;
    logic [7:0]   reg_datao;
    logic         reg_read = 1'b0;
    logic         reg_write = 1'b0;
    logic [31:0]  event_i = '0;
    logic [127:0] counter_i = '0;
    logic [127:0] cfg_o;
    logic [3:0]   pulse_o;
    logic         soft_reset_o;

    reg_capture_bank #(
        .pBYTECNT_SIZE (7),
        .pNUM_CH       (4),
        .pCFG_BYTES    (4),
        .pCFG_RESET    (CRST),
        .pRST_CYCLES   (16)
    ) dut (
        .clk_usb      (clk_usb),
        .reset_n      (reset_n),
        .reg_address  (reg_address),
        .reg_bytecnt  (reg_bytecnt),
        .reg_datai    (reg_datai),
        .reg_datao    (reg_datao),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .event_i      (event_i),
        .counter_i    (counter_i),
        .cfg_o        (cfg_o),
        .pulse_o      (pulse_o),
        .soft_reset_o (soft_reset_o)
    );

    always #5 clk_usb = ~clk_usb;

    // kind: 0 reg_datao, 1 cfg_o, 2 pulse_o, 3 soft_reset_o
    logic [127:0] exp_q[$];
    int           kind_q[$];
    string        name_q[$];
    int           srst_q[$];

    int errors = 0;
    int checks = 0;
    bit obs_req = 1'b0;
    int srst_len = 0;
    int srst_events = 0;
    int to_cnt = 0;
    int to_seen = 0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;

    initial begin : monitor
        logic [127:0] e, act;
        int           k, el;
        string        n;
        forever begin
            @(negedge clk_usb);
            if (obs_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got an observation with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    k = kind_q.pop_front();
                    n = name_q.pop_front();
                    case (k)
                        0:       act = {120'b0, reg_datao};
                        1:       act = cfg_o;
                        2:       act = {124'b0, pulse_o};
                        default: act = {127'b0, soft_reset_o};
                    endcase
                    if (act !== e) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", n, act, e);
                    end
                end
            end
            if (soft_reset_o === 1'b1) begin
                srst_len++;
            end else if (srst_len > 0) begin
                checks++;
                if (srst_q.size() == 0) begin
                    errors++;
                    $display("FAIL srst_len: got unexpected pulse of %0d cycles expected none", srst_len);
                end else begin
                    el = srst_q.pop_front();
                    if (srst_len != el) begin
                        errors++;
                        $display("FAIL srst_len: got %0d cycles expected %0d", srst_len, el);
                    end
                end
                srst_len = 0;
                srst_events++;
            end
            if (to_cnt != to_seen) begin
                to_seen = to_cnt;
                checks++;
                errors++;
                $display("FAIL srst_wait: got no falling edge within 80 cycles expected one");
            end
            if (end_req && !end_done) begin
                checks++;
                if (exp_q.size() != 0 || srst_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: got %0d/%0d pending entries expected 0/0", exp_q.size(), srst_q.size());
                end
                end_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic obs(input int k, input logic [127:0] e, input string n);
        exp_q.push_back(e);
        kind_q.push_back(k);
        name_q.push_back(n);
        obs_req = 1'b1;
        tick();
        obs_req = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
        reg_address = a;
        reg_bytecnt = bc;
        reg_datai   = d;
        reg_write   = 1'b1;
        tick();
        reg_write   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] e, input string n);
        reg_address = a;
        reg_bytecnt = bc;
        reg_read    = 1'b1;
        obs(0, {120'b0, e}, n);
        reg_read    = 1'b0;
    endtask

    task automatic wait_srst(input int start);
        int i;
        i = 0;
        while (srst_events == start && i < 80) begin
            tick();
            i++;
        end
        if (srst_events == start)
            to_cnt++;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test expected $finish before 100us");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] v;
        logic [7:0]  rst_bytes [4];
        int          s;
        rst_bytes[0] = 8'h02; rst_bytes[1] = 8'h01; rst_bytes[2] = 8'h00; rst_bytes[3] = 8'h00;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        obs(1, {CRST, CRST, CRST, CRST}, "cfg_reset");
        obs(2, 128'h0, "pulse_reset");
        obs(3, 128'h0, "srst_reset");
        rd(ADDR_CHSEL, 0, 8'h00, "chsel_reset");
        for (int b = 0; b < 4; b++)
            rd(ADDR_CFG, 7'(b), rst_bytes[b], $sformatf("cfg_rst_ch0_b%0d", b));
        for (int c = 1; c < 4; c++) begin
            wr(ADDR_CHSEL, 0, 8'(c));
            rd(ADDR_CFG, 0, 8'h02, $sformatf("cfg_rst_ch%0d_b0", c));
            rd(ADDR_STAT, 0, 8'h00, $sformatf("stat_rst_ch%0d", c));
        end

        wr(ADDR_CHSEL, 0, 8'h02);
        wr(ADDR_CFG, 0, 8'hAA);
        wr(ADDR_CFG, 1, 8'hBB);
        wr(ADDR_CFG, 2, 8'hCC);
        obs(1, {CRST, CRST, CRST, CRST}, "cfg_partial_no_commit");
        wr(ADDR_CFG, 4, 8'h55);
        wr(ADDR_CFG, 3, 8'hDD);
        obs(1, {CRST, 32'hDDCCBBAA, CRST, CRST}, "cfg_commit_ch2");
        rd(ADDR_CFG, 2, 8'hCC, "cfg_read_ch2_b2");
        wr(ADDR_CHSEL, 0, 8'h07);
        rd(ADDR_CHSEL, 0, 8'h02, "chsel_ignore_7");

        wr(ADDR_CHSEL, 0, 8'h01);
        event_i = 32'h0000_0800;
        tick();
        event_i = '0;
        rd(ADDR_STAT, 0, 8'h08, "stat_set_ch1");
        event_i = 32'h0000_0800;
        wr(ADDR_STAT, 0, 8'h08);
        event_i = '0;
        rd(ADDR_STAT, 0, 8'h08, "stat_race_set_wins");
        wr(ADDR_STAT, 0, 8'h08);
        rd(ADDR_STAT, 0, 8'h00, "stat_w1c");
        event_i = 32'h0000_0100;
        tick();
        event_i = '0;
        rd(ADDR_STAT, 0, 8'h01, "stat_set_b0");
        wr(ADDR_CMD, 0, 8'h02);
        rd(ADDR_STAT, 0, 8'h00, "stat_cmd_clear");

        counter_i = {32'h0, 32'h0, 32'h0000_0A01, 32'h1234_5678};
        wr(ADDR_CHSEL, 0, 8'h00);
        wr(ADDR_CMD, 0, 8'h01);
        counter_i = '1;
        v = 32'h1234_5678;
        for (int b = 0; b < 4; b++)
            rd(ADDR_SNAP, 7'(b), v[b*8 +: 8], $sformatf("snap_ch0_b%0d", b));
        rd(ADDR_SNAP, 4, 8'h00, "snap_b4_zero");
        rd(ADDR_CMD, 0, 8'h00, "cmd_reads_zero");
        wr(ADDR_CHSEL, 0, 8'h01);
        rd(ADDR_SNAP, 1, 8'h0A, "snap_ch1_b1");

        wr(ADDR_CHSEL, 0, 8'h03);
        wr(ADDR_CMD, 0, 8'h04);
        obs(2, 128'h8, "pulse_ch3_high");
        obs(2, 128'h0, "pulse_ch3_low");

        event_i = 32'h2000_0000;
        tick();
        event_i = '0;
        rd(ADDR_STAT, 0, 8'h20, "stat_set_ch3");
        s = srst_events;
        srst_q.push_back(16);
        wr(ADDR_CMD, 0, 8'h08);
        wait_srst(s);
        rd(ADDR_STAT, 0, 8'h00, "stat_after_srst");
        rd(ADDR_CHSEL, 0, 8'h03, "chsel_kept_srst");
        wr(ADDR_CHSEL, 0, 8'h00);
        rd(ADDR_SNAP, 0, 8'h00, "snap_after_srst");
        wr(ADDR_CHSEL, 0, 8'h02);
        rd(ADDR_CFG, 3, 8'hDD, "cfg_kept_srst");

        s = srst_events;
        srst_q.push_back(26);
        wr(ADDR_CMD, 0, 8'h08);
        wr(ADDR_CHSEL, 0, 8'h01);
        repeat (8) tick();
        wr(ADDR_CMD, 0, 8'h08);
        wait_srst(s);
        rd(ADDR_CHSEL, 0, 8'h01, "chsel_write_during_srst");

        counter_i = {32'h0, 32'h0, 32'h0000_0A01, 32'h1234_5678};
        s = srst_events;
        srst_q.push_back(16);
        wr(ADDR_CMD, 0, 8'h0F);
        rd(ADDR_SNAP, 0, 8'h00, "snap_srst_priority");
        wait_srst(s);
        rd(ADDR_SNAP, 0, 8'h00, "snap_after_cmd0f");

        wr(ADDR_CHSEL, 0, 8'h02);
        wr(ADDR_CFG, 0, 8'h11);
        wr(ADDR_CFG, 1, 8'h22);
        #2;
        reset_n = 1'b0;
        obs(1, {CRST, CRST, CRST, CRST}, "cfg_async_reset");
        reset_n = 1'b1;
        wr(ADDR_CFG, 3, 8'h77);
        obs(1, {CRST, CRST, CRST, 32'h7700_0102}, "cfg_commit_after_reset");
        rd(ADDR_CFG, 1, 8'h01, "cfg_read_after_reset");

        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_done; i++)
            tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
